dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between requester 0 (core load/store unit) and requester 1 (debug/DMA port).
- Grants one access at a time and checks alignment and range before issuing.
- Sequences the memory's one-cycle registered read.
- Holds address, size and zero-extend stable through the response cycle, because the memory's lane extraction is combinational on them.
- Returns a valid or error response to the granted requester.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/dmem_arb_check.sv | 36 +++
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the data-memory arbiter slice.
//   - BYTE / HALF_WORD / WORD : load/store size encoding (2'b11 is illegal)
//   - dmem_arb_state_e        : arbiter FSM states
//   - dmem_req_t              : one requester's access fields, used both for
//                               the winner mux and for the response latch
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } dmem_arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wr_data;
        logic        zero_extnd;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arb_check.sv
// ---------------------------------------------------------------------------
// dmem_arb_check
// Combinational legality checker for a single data-memory access.
//   addr         in  32  byte address
//   size         in  2   BYTE / HALF_WORD / WORD
//   misaligned   out 1   access not naturally aligned, or illegal size code
//   out_of_range out 1   address at or beyond 4*DMEM_WORDS bytes
// ---------------------------------------------------------------------------
module dmem_arb_check
    import riscv_pkg::*;
#(
    parameter int DMEM_WORDS = 1024
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        misaligned,
    output logic        out_of_range
);

    // One extra bit so that a memory filling the whole 4 GiB space cannot
    // wrap the limit to zero.
    localparam logic [32:0] BYTE_LIMIT = 33'(DMEM_WORDS) * 33'd4;

    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            BYTE:      misaligned = 1'b0;
            HALF_WORD: misaligned = addr[0];
            WORD:      misaligned = (addr[1:0] != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

    assign out_of_range = ({1'b0, addr} >= BYTE_LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported data memory between requester 0 (core LSU) and
// requester 1 (debug/DMA). One access is accepted per IDLE cycle; the
// following RESP cycle returns the response while the latched address, size
// and extend select keep the memory's combinational lane extraction valid
// for its registered read word.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req_i/addr_i/size_i/wr_i/wr_data_i/zero_extnd_i   per-requester access
//   gnt_o                 one-hot accept, combinational in the request cycle
//   rvalid_o              one-hot response valid, cycle after the grant
//   rdata_o, err_o        shared response bus, qualified by rvalid_o
//   mem_*_o, mem_rd_data_i  data memory interface
//
// Configuration macro: DMEM_ARB_ROUND_ROBIN_EN
//   defined   - round-robin priority using a last-granted pointer
//   undefined - fixed priority, requester 0 always wins
// ---------------------------------------------------------------------------
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int DMEM_WORDS = 1024,
    parameter int NUM_REQ    = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0][31:0] addr_i,
    input  logic [NUM_REQ-1:0][1:0]  size_i,
    input  logic [NUM_REQ-1:0]       wr_i,
    input  logic [NUM_REQ-1:0][31:0] wr_data_i,
    input  logic [NUM_REQ-1:0]       zero_extnd_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    output logic [1:0]               mem_byte_en_o,
    output logic                     mem_wr_o,
    output logic [31:0]              mem_wr_data_o,
    output logic                     mem_zero_extnd_o,
    input  logic [31:0]              mem_rd_data_i
);

    // The winner logic below is written for exactly two requesters.
    if (NUM_REQ != 2) begin : g_num_req_check
        $error("dmem_arbiter supports NUM_REQ == 2 only");
    end

    dmem_arb_state_e state, state_next;
    dmem_req_t       req_q;
    logic            err_q;
    logic            winner_q;

    dmem_req_t       win_req;
    logic            winner;
    logic            any_req;
    logic            misaligned;
    logic            out_of_range;
    logic            legal;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic            rr_ptr;

    // With both requesting, the one not granted last time goes first.
    always_comb begin
        winner = req_i[1];
        if (req_i == 2'b11) begin
            winner = ~rr_ptr;
        end
    end
`else
    // Requester 0 wins whenever it asks.
    always_comb begin
        winner = ~req_i[0];
    end
`endif

    assign any_req = |req_i;

    // Select the winning requester's access fields.
    always_comb begin
        win_req.addr       = addr_i[winner];
        win_req.size       = size_i[winner];
        win_req.wr         = wr_i[winner];
        win_req.wr_data    = wr_data_i[winner];
        win_req.zero_extnd = zero_extnd_i[winner];
    end

    dmem_arb_check #(
        .DMEM_WORDS   (DMEM_WORDS)
    ) u_check (
        .addr         (win_req.addr),
        .size         (win_req.size),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    assign legal = ~misaligned & ~out_of_range;

    // State register plus the response latch. The latch is loaded in every
    // grant cycle, legal or not, so RESP always knows who to answer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            req_q    <= '0;
            err_q    <= 1'b0;
            winner_q <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            rr_ptr   <= 1'b1;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                req_q    <= win_req;
                err_q    <= ~legal;
                winner_q <= winner;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                rr_ptr   <= winner;
`endif
            end
        end
    end

    // Next state and all outputs. Everything is forced quiet while reset_n
    // is low so a response in flight is dropped rather than delivered.
    always_comb begin
        state_next       = state;
        gnt_o            = '0;
        rvalid_o         = '0;
        rdata_o          = '0;
        err_o            = 1'b0;
        mem_req_o        = 1'b0;
        mem_addr_o       = '0;
        mem_byte_en_o    = '0;
        mem_wr_o         = 1'b0;
        mem_wr_data_o    = '0;
        mem_zero_extnd_o = 1'b0;

        if (reset_n) begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_o[winner] = 1'b1;
                        state_next    = RESP;
                        if (legal) begin
                            mem_req_o        = 1'b1;
                            mem_addr_o       = win_req.addr;
                            mem_byte_en_o    = win_req.size;
                            mem_wr_o         = win_req.wr;
                            mem_wr_data_o    = win_req.wr_data;
                            mem_zero_extnd_o = win_req.zero_extnd;
                        end
                    end
                end
                RESP: begin
                    // Keep the lane-select fields stable for the memory's
                    // extraction of its registered read word.
                    mem_addr_o         = req_q.addr;
                    mem_byte_en_o      = req_q.size;
                    mem_wr_data_o      = req_q.wr_data;
                    mem_zero_extnd_o   = req_q.zero_extnd;
                    rvalid_o[winner_q] = 1'b1;
                    err_o              = err_q;
                    if (!req_q.wr && !err_q) begin
                        rdata_o = mem_rd_data_i;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. Includes a simple data memory with a
// registered read word and combinational lane extraction, and a byte-array
// reference model that predicts load data, errors and final memory contents.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    import riscv_pkg::*;

    localparam int DMEM_WORDS = 1024;
    localparam int NUM_REQ    = 2;
    localparam int MEM_BYTES  = 4 * DMEM_WORDS;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ-1:0][31:0] addr_i;
    logic [NUM_REQ-1:0][1:0]  size_i;
    logic [NUM_REQ-1:0]       wr_i;
    logic [NUM_REQ-1:0][31:0] wr_data_i;
    logic [NUM_REQ-1:0]       zero_extnd_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       rvalid_o;
    logic [31:0]              rdata_o;
    logic                     err_o;
    logic                     mem_req_o;
    logic [31:0]              mem_addr_o;
    logic [1:0]               mem_byte_en_o;
    logic                     mem_wr_o;
    logic [31:0]              mem_wr_data_o;
    logic                     mem_zero_extnd_o;
    logic [31:0]              mem_rd_data_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] dev_mem [DMEM_WORDS];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] rd_word;
    logic        mem_loaded = 1'b0;
    logic        last_gnt;

    dmem_arbiter #(
        .DMEM_WORDS       (DMEM_WORDS),
        .NUM_REQ          (NUM_REQ)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_i            (req_i),
        .addr_i           (addr_i),
        .size_i           (size_i),
        .wr_i             (wr_i),
        .wr_data_i        (wr_data_i),
        .zero_extnd_i     (zero_extnd_i),
        .gnt_o            (gnt_o),
        .rvalid_o         (rvalid_o),
        .rdata_o          (rdata_o),
        .err_o            (err_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_byte_en_o    (mem_byte_en_o),
        .mem_wr_o         (mem_wr_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .mem_zero_extnd_o (mem_zero_extnd_o),
        .mem_rd_data_i    (mem_rd_data_i)
    );

    always #5 clk = ~clk;

    // Deterministic initial memory image shared by memory and model.
    function automatic logic [31:0] seedWord(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Data memory: registered read word, byte-lane writes.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DMEM_WORDS; i++) dev_mem[i] = seedWord(i);
            mem_loaded = 1'b1;
        end else if (mem_req_o) begin
            if (mem_wr_o) begin
                case (mem_byte_en_o)
                    BYTE:      dev_mem[mem_addr_o[11:2]][8*mem_addr_o[1:0] +: 8] = mem_wr_data_o[7:0];
                    HALF_WORD: dev_mem[mem_addr_o[11:2]][16*mem_addr_o[1] +: 16] = mem_wr_data_o[15:0];
                    default:   dev_mem[mem_addr_o[11:2]] = mem_wr_data_o;
                endcase
            end else begin
                rd_word <= dev_mem[mem_addr_o[11:2]];
            end
        end
    end

    // Memory's combinational lane extraction on the arbiter's held fields.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = rd_word[8*mem_addr_o[1:0] +: 8];
        h = mem_addr_o[1] ? rd_word[31:16] : rd_word[15:0];
        mem_rd_data_i = rd_word;
        case (mem_byte_en_o)
            BYTE:      mem_rd_data_i = mem_zero_extnd_o ? {24'd0, b} : {{24{b[7]}}, b};
            HALF_WORD: mem_rd_data_i = mem_zero_extnd_o ? {16'd0, h} : {{16{h[15]}}, h};
            default:   mem_rd_data_i = rd_word;
        endcase
    end

    function automatic logic modelLegal(logic [31:0] a, logic [1:0] s);
        logic mis;
        mis = (s == 2'b11) || (s == HALF_WORD && a[0]) || (s == WORD && a[1:0] != 2'b00);
        return !mis && (a < 32'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] modelLoad(logic [31:0] a, logic [1:0] s, logic z);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(a[11:0]);
        if (s == BYTE) begin
            b = ref_mem[i];
            return z ? {24'd0, b} : {{24{b[7]}}, b};
        end else if (s == HALF_WORD) begin
            h = {ref_mem[i+1], ref_mem[i]};
            return z ? {16'd0, h} : {{16{h[15]}}, h};
        end
        return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endfunction

    task automatic modelStore(logic [31:0] a, logic [1:0] s, logic [31:0] d);
        int i;
        i = int'(a[11:0]);
        ref_mem[i] = d[7:0];
        if (s != BYTE) ref_mem[i+1] = d[15:8];
        if (s == WORD) begin
            ref_mem[i+2] = d[23:16];
            ref_mem[i+3] = d[31:24];
        end
    endtask

    task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic driveAccess(int port, logic [31:0] a, logic [1:0] s, logic w,
                               logic [31:0] d, logic z);
        addr_i[port]       = a;
        size_i[port]       = s;
        wr_i[port]         = w;
        wr_data_i[port]    = d;
        zero_extnd_i[port] = z;
        req_i[port]        = 1'b1;
    endtask

    // One access on one port, starting and ending in an IDLE cycle.
    task automatic applyStimulus(int port, logic [31:0] a, logic [1:0] s, logic w,
                                 logic [31:0] d, logic z);
        logic        ok;
        logic [31:0] exp_rdata;
        ok = modelLegal(a, s);
        exp_rdata = (ok && !w) ? modelLoad(a, s, z) : 32'd0;
        @(negedge clk);
        driveAccess(port, a, s, w, d, z);
        #1;
        checkOutput("gnt", 32'(gnt_o), 32'(2'b01 << port));
        checkOutput("mem_req", 32'(mem_req_o), 32'(ok));
        if (ok) begin
            checkOutput("mem_wr", 32'(mem_wr_o), 32'(w));
            checkOutput("mem_addr", mem_addr_o, a);
        end
        @(posedge clk);
        #1;
        req_i = '0;
        addr_i[port]  = $urandom;
        size_i[port]  = 2'($urandom);
        wr_data_i[port] = $urandom;
        zero_extnd_i[port] = 1'($urandom);
        #1;
        checkOutput("rvalid", 32'(rvalid_o), 32'(2'b01 << port));
        checkOutput("err", 32'(err_o), 32'(!ok));
        checkOutput("rdata", rdata_o, exp_rdata);
        checkOutput("resp_mem_req", 32'({mem_req_o, mem_wr_o}), 32'd0);
        checkOutput("resp_gnt", 32'(gnt_o), 32'd0);
        if (ok && w) modelStore(a, s, d);
        last_gnt = 1'(port);
        @(posedge clk);
    endtask

    // Both requesters load at once; each must be served exactly once.
    task automatic dualRequest(logic [31:0] a0, logic [31:0] a1);
        logic        w;
        logic [31:0] aw, al;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        w = ~last_gnt;
`else
        w = 1'b0;
`endif
        aw = w ? a1 : a0;
        al = w ? a0 : a1;
        @(negedge clk);
        driveAccess(0, a0, WORD, 1'b0, 32'd0, 1'b0);
        driveAccess(1, a1, WORD, 1'b0, 32'd0, 1'b0);
        #1;
        checkOutput("dual_gnt_first", 32'(gnt_o), 32'(2'b01 << w));
        @(posedge clk);
        #1;
        req_i[w] = 1'b0;
        #1;
        checkOutput("dual_gnt_hold", 32'(gnt_o), 32'd0);
        checkOutput("dual_rvalid_first", 32'(rvalid_o), 32'(2'b01 << w));
        checkOutput("dual_rdata_first", rdata_o, modelLoad(aw, WORD, 1'b0));
        @(posedge clk);
        #1;
        checkOutput("dual_gnt_second", 32'(gnt_o), 32'(2'b01 << ~w));
        @(posedge clk);
        #1;
        req_i = '0;
        checkOutput("dual_rvalid_second", 32'(rvalid_o), 32'(2'b01 << ~w));
        checkOutput("dual_rdata_second", rdata_o, modelLoad(al, WORD, 1'b0));
        last_gnt = ~w;
        @(posedge clk);
    endtask

    initial begin
        int          port;
        logic [31:0] a;
        logic [1:0]  s;
        int          bad;

        for (int i = 0; i < DMEM_WORDS; i++) begin
            logic [31:0] sw;
            sw = seedWord(i);
            {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]} = sw;
        end
        reset_n      = 1'b0;
        req_i        = 2'b11;
        addr_i       = '0;
        size_i       = '0;
        wr_i         = '0;
        wr_data_i    = '0;
        zero_extnd_i = '0;
        last_gnt     = 1'b1;

        // Outputs stay quiet under reset even with requests pending.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_gnt", 32'(gnt_o), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("reset_mem", 32'({mem_req_o, mem_wr_o, err_o}), 32'd0);
        checkOutput("reset_rdata", rdata_o, 32'd0);
        req_i   = '0;
        reset_n = 1'b1;

        // Directed accesses.
        applyStimulus(0, 32'h10, WORD, 1'b1, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(0, 32'h10, WORD, 1'b0, 32'd0, 1'b0);
        checkOutput("sw_lw_value", modelLoad(32'h10, WORD, 1'b0), 32'hDEAD_BEEF);
        dualRequest(32'h10, 32'h20);
        dualRequest(32'h40, 32'h80);
        dualRequest(32'h44, 32'h88);
        applyStimulus(1, 32'h21, HALF_WORD, 1'b0, 32'd0, 1'b0);
        applyStimulus(1, 32'h1002, WORD, 1'b0, 32'd0, 1'b0);
        applyStimulus(0, 32'h1000, WORD, 1'b0, 32'd0, 1'b0);
        applyStimulus(1, 32'h1000, WORD, 1'b1, 32'h1234_5678, 1'b0);
        applyStimulus(0, 32'h43, BYTE, 1'b1, 32'h0000_0080, 1'b0);
        applyStimulus(0, 32'h43, BYTE, 1'b0, 32'd0, 1'b1);
        applyStimulus(0, 32'h43, BYTE, 1'b0, 32'd0, 1'b0);
        checkOutput("lb_value", modelLoad(32'h43, BYTE, 1'b0), 32'hFFFF_FF80);

        // Reset during RESP drops the pending response.
        @(negedge clk);
        driveAccess(0, 32'h10, WORD, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        req_i   = '0;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_resp_rvalid", 32'(rvalid_o), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput("rst_idle_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("rst_idle_mem_req", 32'(mem_req_o), 32'd0);
        last_gnt = 1'b1;
        applyStimulus(1, 32'h10, WORD, 1'b0, 32'd0, 1'b0);

        // Randomized accesses.
        for (int n = 0; n < 200; n++) begin
            port = int'($urandom_range(0, 1));
            s    = 2'($urandom_range(0, 3));
            if (s == 2'b11 && $urandom_range(0, 3) != 0) s = WORD;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'(MEM_BYTES) + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, MEM_BYTES - 1));
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (s == WORD) a[1:0] = 2'b00;
                if (s == HALF_WORD) a[0] = 1'b0;
            end
            if ((n % 25) == 0) dualRequest(32'($urandom_range(0, 1023)) << 2,
                                           32'($urandom_range(0, 1023)) << 2);
            applyStimulus(port, a, s, 1'($urandom), $urandom, 1'($urandom));
        end

        // Final memory image must equal the model: no stray or lost writes.
        bad = 0;
        for (int i = 0; i < DMEM_WORDS; i++) begin
            if (dev_mem[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]})
                bad++;
        end
        checkOutput("mem_image", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
